cpu_bus_ack: RTL and testbench
==============================

Name: cpu_bus_ack

Overview:
- Downstream consumer of the CPU chip-select decode; sits between the decoded active-low selects and the 68000 DTACK input.
- Per 68000 bus cycle: latches which region is selected, then either runs a per-region wait-state count or performs a request/acknowledge handshake with the SDRAM arbiter (ROM and work RAM).
- Drives a registered cpu_dtack_n back to the CPU.
- Includes a memory-timeout guard so a lost acknowledge cannot hang the CPU.

Parameters:
- WS_IO, 1: wait ticks for IO0/IO1/SOUND/EXTENSION/PRIORITY/SS selects.
- WS_VIDEO, 2: wait ticks for SCREEN/OBJECT/COLOR selects.
- WS_UNMAPPED, 4: wait ticks when no select is active.
- MEM_TIMEOUT, 1023: clk cycles allowed in a memory wait before forced completion; 10-bit counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  CPU clock-enable tick; wait states count in ce ticks.
- cpu_as_n  in  1  68000 address strobe.
- cpu_ds_n  in  2  68000 data strobes, [1]=upper, [0]=lower.
- cpu_rw  in  1  1=read.
- cs_n  in  CS_COUNT  active-low selects from the decoder, indexed by package constants.
- mem_req  out  1  SDRAM request level.
- mem_we  out  1  write qualifier, valid while mem_req is high.
- mem_be  out  2  byte enables (~cpu_ds_n latched), valid while mem_req is high.
- mem_ack  in  1  single-cycle acknowledge from the arbiter.
- cpu_dtack_n  out  1  registered DTACK to the CPU.
- mem_timeout  out  1  sticky flag, set on any timeout; cleared only by reset.

Behaviour:
- Reset (async, reset_n low): state IDLE, cpu_dtack_n=1, mem_req=0, mem_we=0, mem_be=0, mem_timeout=0, counters=0, cs latch all-1.
- Cycle start: in IDLE, on the first clk edge where cpu_as_n=0 and ~&cpu_ds_n. This covers late-DS writes. Latch cs_n, cpu_rw and ~cpu_ds_n on that edge.
- Classification from latched cs:
  - ROM or WORK active → MEM path. MEM wins over any other select.
  - Otherwise the maximum wait of all active selects.
  - No select active → WS_UNMAPPED.
- States:
  - IDLE: start → WAIT_MEM (assert mem_req, mem_we=~rw, mem_be on the same edge); or → WAIT_CNT with counter=ws; ws=0 → ACK directly.
  - WAIT_CNT: counter decrements on ce. The edge where counter is 1 and ce is high → ACK. cpu_as_n high → IDLE, no DTACK.
  - WAIT_MEM: timeout counter increments every clk.
    - mem_ack=1 → mem_req=0, → ACK.
    - Counter reaches MEM_TIMEOUT → mem_req=0, mem_timeout=1, → ACK.
    - cpu_as_n high while waiting → DRAIN. The request cannot be cancelled.
    - mem_ack and cpu_as_n high on the same edge → IDLE.
  - DRAIN: mem_req held until mem_ack or timeout, then → IDLE. No DTACK is asserted.
  - ACK: cpu_dtack_n=0 registered on entry. On the first edge with cpu_as_n=1: cpu_dtack_n=1, → IDLE.
- Latency:
  - Zero-wait region: DTACK low 2 clk edges after AS/DS are sampled low (start edge, then ACK edge).
  - MEM: DTACK low on the edge after mem_ack is sampled.
- Back-to-back cycles: IDLE only accepts a new start after ACK, WAIT_CNT or DRAIN has observed cpu_as_n high. No double-ack is possible.
- Unchanged during a cycle: cs_n, cpu_ds_n and cpu_rw changes after the start edge have no effect.
- mem_ack outside WAIT_MEM/DRAIN: ignored.
- mem_req never re-asserts before mem_ack or timeout of the previous request.
- Reset mid-cycle: all outputs return to reset values immediately. The arbiter is responsible for discarding an orphaned request.

Decomposition:
- Shared package (system_consts):
  - Index constants CS_ROM, CS_WORK, CS_SCREEN, CS_OBJ, CS_COLOR, CS_IO0, CS_IO1, CS_SOUND, CS_PRIORITY, CS_EXTENSION, CS_SS, and CS_COUNT=11.
  - Enum bus_ack_state_t {IDLE, WAIT_CNT, WAIT_MEM, DRAIN, ACK}.
- One natural sub-module: bus_ws_select. It is combinational: latched cs vector plus parameters → {is_mem, ws[3:0]}. It can be tested standalone.
- The top level holds the FSM and counters.

Test Plan:
- SCREEN read, WS_VIDEO=2, ce every 4 clk → DTACK low after exactly 2 ce ticks. After AS high, DTACK high 1 clk later. mem_req never high.
- ROM read, mem_ack returned 7 clk after the request → mem_req high 7 clk, mem_be=2'b11, mem_we=0. DTACK low the next edge. mem_timeout=0.
- WORK lower-byte write with DS asserted 2 clk after AS → start on the DS edge. mem_we=1, mem_be=2'b01.
- ROM read with mem_ack never returned → mem_req drops at clk 1023. DTACK asserts and mem_timeout=1, staying set across subsequent cycles until reset_n pulses.
- No select active, WS_UNMAPPED=4 → DTACK after 4 ce ticks. cs_n=0x7FE (ROM only) plus SCREEN also low → MEM path taken.
- WORK request with AS released before mem_ack → DRAIN. DTACK stays high and mem_req holds until ack. A new cycle immediately after is accepted only once the FSM returns to IDLE.

Source files
------------

// File: rtl/cpu_bus_ack_pkg.sv
// Shared constants for the CPU bus: chip-select indices and
// the DTACK generator state encoding.
package system_consts;

  localparam int CS_ROM       = 0;
  localparam int CS_WORK      = 1;
  localparam int CS_SCREEN    = 2;
  localparam int CS_OBJ       = 3;
  localparam int CS_COLOR     = 4;
  localparam int CS_IO0       = 5;
  localparam int CS_IO1       = 6;
  localparam int CS_SOUND     = 7;
  localparam int CS_PRIORITY  = 8;
  localparam int CS_EXTENSION = 9;
  localparam int CS_SS        = 10;
  localparam int CS_COUNT     = 11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CNT,
    WAIT_MEM,
    DRAIN,
    ACK
  } bus_ack_state_t;

  function automatic logic [3:0] ws_max(
    input logic [3:0] a,
    input logic [3:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_bus_ack_ws_select.sv
// Region classifier: active-low select vector to
// memory-path flag plus worst-case wait-state count.
module bus_ws_select
  import system_consts::*;
#(
  parameter int WS_IO       = 1,
  parameter int WS_VIDEO    = 2,
  parameter int WS_UNMAPPED = 4
) (
  input  logic [CS_COUNT-1:0] i_cs_n,
  output logic                o_is_mem,
  output logic [3:0]          o_ws
);

  localparam logic [3:0] LP_IO  = 4'(WS_IO);
  localparam logic [3:0] LP_VID = 4'(WS_VIDEO);
  localparam logic [3:0] LP_UNM = 4'(WS_UNMAPPED);

  logic [CS_COUNT-1:0] w_sel;
  logic                w_io;
  logic                w_vid;

  assign w_sel = ~i_cs_n;

  assign w_io = w_sel[CS_IO0] | w_sel[CS_IO1]
              | w_sel[CS_SOUND] | w_sel[CS_EXTENSION]
              | w_sel[CS_PRIORITY] | w_sel[CS_SS];

  assign w_vid = w_sel[CS_SCREEN] | w_sel[CS_OBJ]
               | w_sel[CS_COLOR];

  always_comb begin
    o_is_mem = w_sel[CS_ROM] | w_sel[CS_WORK];
    o_ws     = '0;
    if (w_io)
      o_ws = ws_max(o_ws, LP_IO);
    if (w_vid)
      o_ws = ws_max(o_ws, LP_VID);
    if (~|w_sel)
      o_ws = LP_UNM;
    // SDRAM regions complete on acknowledge, not on a count
    if (o_is_mem)
      o_ws = '0;
  end

endmodule

// File: rtl/cpu_bus_ack.sv
// 68000 DTACK generator: per-region wait states or SDRAM
// request/acknowledge, with a timeout guard on memory waits.
module cpu_bus_ack
  import system_consts::*;
#(
  parameter int WS_IO       = 1,
  parameter int WS_VIDEO    = 2,
  parameter int WS_UNMAPPED = 4,
  parameter int MEM_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                cpu_as_n,
  input  logic [1:0]          cpu_ds_n,
  input  logic                cpu_rw,
  input  logic [CS_COUNT-1:0] cs_n,
  output logic                mem_req,
  output logic                mem_we,
  output logic [1:0]          mem_be,
  input  logic                mem_ack,
  output logic                cpu_dtack_n,
  output logic                mem_timeout
);

  localparam logic [9:0] LP_TMO_LAST =
    10'(MEM_TIMEOUT - 1);

  bus_ack_state_t r_state, w_state;

  logic [CS_COUNT-1:0] r_cs, w_cs;
  logic [3:0]          r_wcnt, w_wcnt;
  logic [9:0]          r_tcnt, w_tcnt;
  logic                r_req, w_req;
  logic                r_we, w_we;
  logic [1:0]          r_be, w_be;
  logic                r_dtack_n, w_dtack_n;
  logic                r_tmo, w_tmo;

  logic [CS_COUNT-1:0] w_cs_cls;
  logic                w_is_mem;
  logic [3:0]          w_ws;
  logic                w_start;
  logic                w_tmo_hit;

  // classify live selects on the start edge, latched after
  assign w_cs_cls = (r_state == IDLE) ? cs_n : r_cs;

  bus_ws_select #(
    .WS_IO       (WS_IO),
    .WS_VIDEO    (WS_VIDEO),
    .WS_UNMAPPED (WS_UNMAPPED)
  ) u_ws_select (
    .i_cs_n   (w_cs_cls),
    .o_is_mem (w_is_mem),
    .o_ws     (w_ws)
  );

  assign w_start   = ~cpu_as_n & ~&cpu_ds_n;
  assign w_tmo_hit = (r_tcnt == LP_TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cs      <= '1;
      r_wcnt    <= '0;
      r_tcnt    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 2'b00;
      r_dtack_n <= 1'b1;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cs      <= w_cs;
      r_wcnt    <= w_wcnt;
      r_tcnt    <= w_tcnt;
      r_req     <= w_req;
      r_we      <= w_we;
      r_be      <= w_be;
      r_dtack_n <= w_dtack_n;
      r_tmo     <= w_tmo;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cs      = r_cs;
    w_wcnt    = r_wcnt;
    w_tcnt    = r_tcnt;
    w_req     = r_req;
    w_we      = r_we;
    w_be      = r_be;
    w_dtack_n = r_dtack_n;
    w_tmo     = r_tmo;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_cs = cs_n;
          if (w_is_mem) begin
            w_state = WAIT_MEM;
            w_req   = 1'b1;
            w_we    = ~cpu_rw;
            w_be    = ~cpu_ds_n;
            w_tcnt  = '0;
          end else if (w_ws == 4'd0) begin
            w_state = ACK;
          end else begin
            w_state = WAIT_CNT;
            w_wcnt  = w_ws;
          end
        end
      end

      WAIT_CNT: begin
        if (cpu_as_n) begin
          w_state = IDLE;
        end else if (ce) begin
          if (r_wcnt <= 4'd1)
            w_state = ACK;
          else
            w_wcnt = r_wcnt - 4'd1;
        end
      end

      WAIT_MEM: begin
        w_tcnt = r_tcnt + 10'd1;
        if (mem_ack || w_tmo_hit) begin
          w_req   = 1'b0;
          w_we    = 1'b0;
          w_be    = 2'b00;
          w_tmo   = r_tmo | ~mem_ack;
          w_state = cpu_as_n ? IDLE : ACK;
        end else if (cpu_as_n) begin
          w_state = DRAIN;
        end
      end

      // request already issued; hold it until it retires
      DRAIN: begin
        w_tcnt = r_tcnt + 10'd1;
        if (mem_ack || w_tmo_hit) begin
          w_req   = 1'b0;
          w_we    = 1'b0;
          w_be    = 2'b00;
          w_tmo   = r_tmo | ~mem_ack;
          w_state = IDLE;
        end
      end

      ACK: begin
        if (cpu_as_n) begin
          w_dtack_n = 1'b1;
          w_state   = IDLE;
        end else begin
          w_dtack_n = 1'b0;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_be      = r_be;
  assign cpu_dtack_n = r_dtack_n;
  assign mem_timeout = r_tmo;

endmodule

// File: tb/tb_cpu_bus_ack.sv
// Directed bench for cpu_bus_ack with an expected-value
// queue drained as the DUT responds.
module tb_cpu_bus_ack;
  import system_consts::*;

  logic                clk;
  logic                reset_n;
  logic                ce;
  logic                cpu_as_n;
  logic [1:0]          cpu_ds_n;
  logic                cpu_rw;
  logic [CS_COUNT-1:0] cs_n;
  logic                mem_req;
  logic                mem_we;
  logic [1:0]          mem_be;
  logic                mem_ack;
  logic                cpu_dtack_n;
  logic                mem_timeout;

  localparam logic [10:0] ONE = 11'd1;
  localparam logic [10:0] N_ROM = ~(ONE << CS_ROM);
  localparam logic [10:0] N_WORK = ~(ONE << CS_WORK);
  localparam logic [10:0] N_SCR = ~(ONE << CS_SCREEN);
  localparam logic [10:0] N_IO0 = ~(ONE << CS_IO0);
  localparam logic [10:0] N_IOCOL =
    ~((ONE << CS_IO0) | (ONE << CS_COLOR));

  int exp_q[$];
  int n_pass;
  int n_total;
  int ce_period;
  int ce_cnt;
  int ce_ticks;

  cpu_bus_ack dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .cpu_as_n    (cpu_as_n),
    .cpu_ds_n    (cpu_ds_n),
    .cpu_rw      (cpu_rw),
    .cs_n        (cs_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .cpu_dtack_n (cpu_dtack_n),
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ce_cnt = ce_cnt + 1;
    if (ce_cnt >= ce_period)
      ce_cnt = 0;
    ce = (ce_cnt == 0);
  end

  always @(posedge clk)
    if (ce)
      ce_ticks = ce_ticks + 1;

  task automatic expect_v(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input int obs);
    int e;
    e = -1;
    if (exp_q.size() > 0)
      e = exp_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, e);
  endtask

  task automatic start(input logic [10:0] cs,
                       input logic rw,
                       input logic [1:0] ds);
    cs_n     = cs;
    cpu_rw   = rw;
    cpu_ds_n = ds;
    cpu_as_n = 1'b0;
  endtask

  task automatic wait_dtack(output int n,
                            output int saw);
    n   = 0;
    saw = 0;
    while (cpu_dtack_n !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (mem_req)
        saw = 1;
    end
  endtask

  task automatic release_bus();
    int k;
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cpu_dtack_n !== 1'b1 && k < 20);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int saw;
    int t0;
    n_pass    = 0;
    n_total   = 0;
    ce_period = 1;
    ce_cnt    = 0;
    ce_ticks  = 0;
    ce        = 1'b0;
    reset_n   = 1'b0;
    cpu_as_n  = 1'b1;
    cpu_ds_n  = 2'b11;
    cpu_rw    = 1'b1;
    cs_n      = '1;
    mem_ack   = 1'b0;

    repeat (3) @(negedge clk);
    expect_v(1); chk("rst_dtack", int'(cpu_dtack_n));
    expect_v(0); chk("rst_req", int'(mem_req));
    expect_v(0); chk("rst_we", int'(mem_we));
    expect_v(0); chk("rst_be", int'(mem_be));
    expect_v(0); chk("rst_tmo", int'(mem_timeout));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SCREEN read, ce every 4 clk
    ce_period = 4;
    start(N_SCR, 1'b1, 2'b00);
    expect_v(2);
    expect_v(0);
    @(negedge clk);
    t0 = ce_ticks;
    wait_dtack(n, saw);
    chk("scr_ticks", ce_ticks - t0);
    chk("scr_req", saw);
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    expect_v(1);
    @(negedge clk);
    chk("scr_release", int'(cpu_dtack_n));
    @(negedge clk);

    // ROM read, ack 7 clk after request
    ce_period = 1;
    start(N_ROM, 1'b1, 2'b00);
    expect_v(1);
    expect_v(3);
    expect_v(0);
    @(negedge clk);
    chk("rom_req", int'(mem_req));
    chk("rom_be", int'(mem_be));
    chk("rom_we", int'(mem_we));
    n = mem_req ? 1 : 0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (mem_req)
        n++;
    end
    mem_ack = 1'b1;
    expect_v(7);
    expect_v(0);
    expect_v(1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rom_req_len", n);
    chk("rom_req_drop", int'(mem_req));
    chk("rom_dtack_early", int'(cpu_dtack_n));
    expect_v(0);
    expect_v(0);
    @(negedge clk);
    chk("rom_dtack", int'(cpu_dtack_n));
    chk("rom_tmo", int'(mem_timeout));
    release_bus();

    // WORK lower-byte write, DS late by 2 clk
    start(N_WORK, 1'b0, 2'b11);
    expect_v(0);
    repeat (2) @(negedge clk);
    chk("late_ds_nostart", int'(mem_req));
    cpu_ds_n = 2'b10;
    expect_v(1);
    expect_v(1);
    expect_v(1);
    @(negedge clk);
    chk("wr_req", int'(mem_req));
    chk("wr_we", int'(mem_we));
    chk("wr_be", int'(mem_be));
    cs_n   = '1;
    cpu_rw = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    expect_v(1);
    wait_dtack(n, saw);
    chk("wr_dtack_lat", n);
    release_bus();

    // ROM read, ack never returned
    start(N_ROM, 1'b1, 2'b00);
    expect_v(1023);
    expect_v(1);
    expect_v(0);
    @(negedge clk);
    n = 0;
    while (mem_req && n < 1100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_len", n);
    chk("tmo_flag", int'(mem_timeout));
    @(negedge clk);
    chk("tmo_dtack", int'(cpu_dtack_n));
    release_bus();

    start(N_IO0, 1'b1, 2'b00);
    expect_v(3);
    expect_v(1);
    wait_dtack(n, saw);
    chk("io0_lat", n);
    chk("tmo_sticky", int'(mem_timeout));
    release_bus();

    start(N_IOCOL, 1'b1, 2'b00);
    expect_v(4);
    wait_dtack(n, saw);
    chk("io_col_max_lat", n);
    release_bus();

    // reset during an outstanding request
    start(N_ROM, 1'b1, 2'b00);
    expect_v(1);
    repeat (3) @(negedge clk);
    chk("mid_req", int'(mem_req));
    reset_n = 1'b0;
    expect_v(0);
    expect_v(0);
    expect_v(1);
    #1;
    chk("mid_rst_req", int'(mem_req));
    chk("mid_rst_tmo", int'(mem_timeout));
    chk("mid_rst_dtack", int'(cpu_dtack_n));
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // unmapped, ce every 4 clk
    ce_period = 4;
    start('1, 1'b1, 2'b00);
    expect_v(4);
    expect_v(0);
    @(negedge clk);
    t0 = ce_ticks;
    wait_dtack(n, saw);
    chk("unm_ticks", ce_ticks - t0);
    chk("unm_req", saw);
    release_bus();

    // ROM plus SCREEN selected: memory path wins
    start(11'h7FA, 1'b1, 2'b00);
    expect_v(1);
    @(negedge clk);
    chk("rom_scr_req", int'(mem_req));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    expect_v(1);
    wait_dtack(n, saw);
    chk("rom_scr_lat", n);
    release_bus();

    // WORK request abandoned, then a new cycle
    ce_period = 1;
    start(N_WORK, 1'b1, 2'b00);
    expect_v(1);
    @(negedge clk);
    chk("drn_req", int'(mem_req));
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    expect_v(1);
    expect_v(1);
    repeat (4) @(negedge clk);
    chk("drn_hold", int'(mem_req));
    chk("drn_dtack", int'(cpu_dtack_n));
    start(N_SCR, 1'b1, 2'b00);
    expect_v(1);
    expect_v(1);
    repeat (2) @(negedge clk);
    chk("drn_hold2", int'(mem_req));
    chk("drn_dtack2", int'(cpu_dtack_n));
    mem_ack = 1'b1;
    expect_v(0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("drn_req_drop", int'(mem_req));
    expect_v(4);
    expect_v(0);
    wait_dtack(n, saw);
    chk("after_drn_lat", n);
    chk("after_drn_req", saw);
    release_bus();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
